// File: rtl/knf_pkg.sv
// Shared constants for the CNF input sequencer: operand width and mode encodings.
package knf_pkg;

    localparam int X_W = 4;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_AUTO   = 2'b01,
        MODE_STEP   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a
// registered rising-edge detector producing a single press pulse.
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int              CNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic             sync_0;
    logic             sync_1;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // Bring the raw button into the clock domain before anything looks at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_0 <= 1'b0;
            sync_1 <= 1'b0;
        end else begin
            sync_0 <= raw;
            sync_1 <= sync_0;
        end
    end

    // Accept a new level only after it has disagreed with the accepted one for DEB_CYCLES straight cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_1 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            level <= sync_1;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // One-cycle pulse on the accepted 0->1 transition; release is silent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/knf_input_sequencer.sv
// Operand source for the 4-input CNF block: switches pass-through, a slow
// auto sweep, or single-step from a debounced button, with a clear button.
module knf_input_sequencer
    import knf_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [X_W-1:0] sw,
    input  logic [1:0]     mode,
    input  logic           btn_step,
    input  logic           btn_clr,
    output logic [X_W-1:0] x,
    output logic           x_upd,
    output logic           wrap
);

    localparam int               TICK_W   = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

    logic [X_W-1:0]    sw_s0;
    logic [X_W-1:0]    sw_s1;
    logic [1:0]        mode_s0;
    logic [1:0]        mode_s1;
    mode_t             mode_sync;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic              step_press;
    logic              clr_press;
    logic              step_level;
    logic              clr_level;
    logic              unused_levels;
    logic [X_W-1:0]    x_next;
    logic              incr;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_step),
        .level (step_level),
        .press (step_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_clr),
        .level (clr_level),
        .press (clr_press)
    );

    assign unused_levels = step_level ^ clr_level;
    assign mode_sync     = mode_t'(mode_s1);
    assign tick          = (mode_sync == MODE_AUTO) && (tick_cnt == TICK_MAX);

    // Synchronize the slide and mode switches; all decisions use the second stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s0   <= '0;
            sw_s1   <= '0;
            mode_s0 <= 2'b00;
            mode_s1 <= 2'b00;
        end else begin
            sw_s0   <= sw;
            sw_s1   <= sw_s0;
            mode_s0 <= mode;
            mode_s1 <= mode_s0;
        end
    end

    // Auto-step divider, held at zero outside AUTO so every AUTO entry waits a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (mode_sync != MODE_AUTO) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_MAX) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Pick the next operand: clear beats everything except DIRECT, then the mode's own source.
    always_comb begin
        x_next = x;
        incr   = 1'b0;
        if (clr_press && (mode_sync != MODE_DIRECT)) begin
            x_next = '0;
        end else if (mode_sync == MODE_DIRECT) begin
            x_next = sw_s1;
        end else if (((mode_sync == MODE_AUTO) && tick) ||
                     ((mode_sync == MODE_STEP) && step_press)) begin
            x_next = x + 1'b1;
            incr   = 1'b1;
        end
    end

    // Register the operand and flag real changes, marking increments that roll over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x     <= '0;
            x_upd <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            x     <= x_next;
            x_upd <= (x_next != x);
            wrap  <= incr && (x == {X_W{1'b1}});
        end
    end

endmodule
